// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
// Imported by seq_alu and its bench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ripple_adder.sv
// Full-adder cell and a generate-chained ripple-carry adder.
// Shared by add, subtract and the multiply accumulation.
module full_adder (
    input  logic in_a,
    input  logic in_b,
    input  logic in_c,
    output logic out_sum,
    output logic out_c
);
    assign out_sum = in_a ^ in_b ^ in_c;
    assign out_c   = (in_a & in_b) | (in_c & (in_a ^ in_b));
endmodule

module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c
);
    // One scope per bit keeps each carry a distinct net.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = in_c;
        end else begin : g_next
            assign ci = g_fa[i-1].co;
        end
        full_adder u_fa (
            .in_a   (in_a[i]),
            .in_b   (in_b[i]),
            .in_c   (ci),
            .out_sum(out_sum[i]),
            .out_c  (co)
        );
    end

    assign out_c = g_fa[WIDTH-1].co;
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, WIDTH-cycle
// shift-add multiply, valid/ready handshakes on both sides.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_opcode,
    input  logic               in_valid,
    output logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_zero,
    output logic               out_valid,
    input  logic               in_result_ready
);
    localparam int SW = $clog2(WIDTH);
    localparam int RW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    result_q, result_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_ci, add_co;
    logic [RW-1:0]    op_res, mul_next;
    logic [SW-1:0]    shamt;

    assign shamt = in_b[SW-1:0];

    // During CALC the adder belongs to the multiply accumulator.
    always_comb begin
        add_a  = in_a;
        add_b  = in_b;
        add_ci = 1'b0;
        if (state_q == ST_CALC) begin
            add_a = acc_q[RW-1:WIDTH];
            add_b = mcand_q;
        end else if (in_opcode == OP_SUB) begin
            add_b  = ~in_b;
            add_ci = 1'b1;
        end
    end

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .in_a   (add_a),
        .in_b   (add_b),
        .in_c   (add_ci),
        .out_sum(add_sum),
        .out_c  (add_co)
    );

    always_comb begin
        op_res = '0;
        case (in_opcode)
            OP_ADD, OP_SUB: op_res[WIDTH:0] = {add_co, add_sum};
            OP_AND: op_res[WIDTH-1:0] = in_a & in_b;
            OP_OR:  op_res[WIDTH-1:0] = in_a | in_b;
            OP_XOR: op_res[WIDTH-1:0] = in_a ^ in_b;
            OP_SHL: op_res[WIDTH-1:0] = in_a << shamt;
            OP_SHR: op_res[WIDTH-1:0] = in_a >> shamt;
            default: op_res = '0;
        endcase
    end

    assign mul_next = acc_q[0]
        ? {add_co, add_sum, acc_q[WIDTH-1:1]}
        : {1'b0, acc_q[RW-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_opcode == OP_MUL) begin
                        state_d = ST_CALC;
                        cnt_d   = SW'(WIDTH - 1);
                        mcand_d = in_a;
                        acc_d   = {{WIDTH{1'b0}}, in_b};
                    end else begin
                        state_d  = ST_DONE;
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                acc_d = mul_next;
                if (cnt_q == '0) begin
                    state_d  = ST_DONE;
                    result_d = mul_next;
                    zero_d   = (mul_next == '0);
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (in_result_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign out_ready  = (state_q == ST_IDLE) && !in_rst;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_valid  = valid_q;
endmodule
